dmem_sram_bridge: RTL

Data-memory bridge between the memory stage of the five-stage MIPS datapath and an SRAM-like data bus (req/addr_ok/data_ok handshake). It accepts one load or store per memory-stage instruction, runs the bus handshake and stalls the pipeline until the access completes. It returns sign- or zero-extended load data and holds it stable until the pipeline advances.

---
 rtl/dmem_sram_bridge.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_sram_bridge.sv
// Memory-stage load/store bridge onto a req/addr_ok/data_ok SRAM-like bus.
// Holds the pipeline until the access completes and keeps load data until advance.
module dmem_sram_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        mem_excep,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_wdata,
  input  logic        advance,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        wr_q, wr_d;
  logic        acc;
  logic        capture;

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'd0:    return {4{w[7:0]}};
      2'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic sgn,
                                          input logic [1:0] lo, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = lo[1] ? r[31:16] : r[15:0];
    case (size)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return r;
    endcase
  endfunction

  assign acc = (mem_ren | mem_wen) & ~mem_excep;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    wr_d     = wr_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d   = mem_addr;
          size_d   = mem_size;
          signed_d = mem_signed;
          wr_d     = mem_wen;
          wdata_d  = replicate(mem_size, mem_wdata);
          state_d  = REQ;
        end
      end
      REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Stores leave the previous load result untouched.
    if (capture && !wr_q) rdata_d = extract(size_q, signed_q, addr_q[1:0], data_rdata);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wr_q     <= wr_d;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_stall  = acc & (state_q != DONE);
  assign data_req   = (state_q == REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule
